// File: rtl/light_pkg.sv
// Shared types and constants for the light-bus tracker and its one-hot encoder.
package light_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        ONEHOT = 2'd1,
        MULTI  = 2'd2
    } sample_cls_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/light_onehot_enc.sv
// Combinational classifier for the light bus: ZERO / ONEHOT / MULTI plus the
// binary index of the (highest) set bit.
module light_onehot_enc
    import light_pkg::*;
#(
    parameter  int N  = 8,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  lights,
    output logic [PW-1:0] idx,
    output sample_cls_t   cls
);

    logic any_set;
    logic many_set;

    always_comb begin
        idx      = '0;
        any_set  = 1'b0;
        many_set = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (lights[i]) begin
                if (any_set) many_set = 1'b1;
                any_set = 1'b1;
                idx     = PW'(i);
            end
        end
        if (many_set)     cls = MULTI;
        else if (any_set) cls = ONEHOT;
        else              cls = ZERO;
    end

endmodule

// File: rtl/light_tracker.sv
// Tracks the lit position on a one-hot light bus, its direction and error events.
// Optional reversal counter enabled by defining LIGHT_TRACKER_BOUNCE_CNT_EN.
module light_tracker
    import light_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int CNT_W = 8,
    localparam int PW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [N-1:0]     lights,
`ifdef LIGHT_TRACKER_BOUNCE_CNT_EN
    output logic [CNT_W-1:0] bounce_cnt,
`endif
    output logic [PW-1:0]    pos,
    output logic             pos_valid,
    output logic             dir,
    output logic             moving,
    output logic             fault,
    output logic             edge_hit,
    output logic             bounce,
    output logic             lost,
    output logic             err
);

    logic [PW-1:0] idx_p0;
    sample_cls_t   cls_p0;

    light_onehot_enc #(.N(N)) u_enc (
        .lights (lights),
        .idx    (idx_p0),
        .cls    (cls_p0)
    );

    state_t        state_p1, state_n;
    logic [PW-1:0] pos_p1, pos_n;
    logic          dir_p1, dir_n;
    logic          edge_n, bounce_n, lost_n, err_n;
    logic          step_up, step_dn, was_valid;

    always_comb begin
        step_up   = (pos_p1 != PW'(N - 1)) && (idx_p0 == pos_p1 + PW'(1));
        step_dn   = (pos_p1 != '0) && (idx_p0 == pos_p1 - PW'(1));
        was_valid = (state_p1 == LOCK) || (state_p1 == TRACK);
        state_n   = state_p1;
        pos_n     = pos_p1;
        dir_n     = dir_p1;
        bounce_n  = 1'b0;
        lost_n    = 1'b0;
        err_n     = 1'b0;
        edge_n    = 1'b0;
        if (ena) begin
            if (cls_p0 == ZERO) begin
                if (was_valid) begin
                    state_n = IDLE;
                    lost_n  = 1'b1;
                end
            end else if (cls_p0 == MULTI) begin
                state_n = FAULT;
                err_n   = (state_p1 != FAULT);
            end else begin
                unique case (state_p1)
                    IDLE, FAULT: begin
                        state_n = LOCK;
                        pos_n   = idx_p0;
                    end
                    LOCK: begin
                        if (step_up || step_dn) begin
                            state_n = TRACK;
                            pos_n   = idx_p0;
                            dir_n   = step_up ? DIR_LEFT : DIR_RIGHT;
                        end else if (idx_p0 != pos_p1) begin
                            state_n = FAULT;
                            err_n   = 1'b1;
                        end
                    end
                    TRACK: begin
                        if (step_up || step_dn) begin
                            pos_n = idx_p0;
                            dir_n = step_up ? DIR_LEFT : DIR_RIGHT;
                            bounce_n = (dir_n != dir_p1);
                        end else if (idx_p0 == pos_p1) begin
                            state_n = LOCK;
                        end else begin
                            state_n = FAULT;
                            err_n   = 1'b1;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
            // A freshly acquired lock counts as pos newly becoming its value.
            edge_n = ((state_n == LOCK) || (state_n == TRACK))
                   && (!was_valid || (pos_n != pos_p1))
                   && ((pos_n == '0) || (pos_n == PW'(N - 1)));
        end
    end

    // Stage p1: registered state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= IDLE;
            pos_p1   <= '0;
            dir_p1   <= DIR_RIGHT;
            edge_hit <= 1'b0;
            bounce   <= 1'b0;
            lost     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_p1 <= state_n;
            pos_p1   <= pos_n;
            dir_p1   <= dir_n;
            edge_hit <= edge_n;
            bounce   <= bounce_n;
            lost     <= lost_n;
            err      <= err_n;
        end
    end

    assign pos       = pos_p1;
    assign dir       = dir_p1;
    assign pos_valid = (state_p1 == LOCK) || (state_p1 == TRACK);
    assign moving    = (state_p1 == TRACK);
    assign fault     = (state_p1 == FAULT);

`ifdef LIGHT_TRACKER_BOUNCE_CNT_EN
    logic [CNT_W-1:0] cnt_p1;

    always_ff @(posedge clk) begin
        if (rst)           cnt_p1 <= '0;
        else if (bounce_n) cnt_p1 <= cnt_p1 + CNT_W'(1);
    end

    assign bounce_cnt = cnt_p1;
`endif

endmodule

// File: tb/tb_light_tracker.sv
// Scoreboard bench for light_tracker: driver pushes model predictions, monitor
// pops one per cycle after the clock edge and compares against the DUT.
module tb_light_tracker;
    localparam int N     = 8;
    localparam int CNT_W = 8;
    localparam int PW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic [N-1:0]     lights = '0;
    logic [PW-1:0]    pos;
    logic             pos_valid, dir, moving, fault, edge_hit, bounce, lost, err;
    logic [CNT_W-1:0] cnt_obs;

`ifdef LIGHT_TRACKER_BOUNCE_CNT_EN
    logic [CNT_W-1:0] bounce_cnt;
    assign cnt_obs = bounce_cnt;
`else
    assign cnt_obs = '0;
`endif

    light_tracker #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .lights     (lights),
`ifdef LIGHT_TRACKER_BOUNCE_CNT_EN
        .bounce_cnt (bounce_cnt),
`endif
        .pos        (pos),
        .pos_valid  (pos_valid),
        .dir        (dir),
        .moving     (moving),
        .fault      (fault),
        .edge_hit   (edge_hit),
        .bounce     (bounce),
        .lost       (lost),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0]    pos;
        logic             pos_valid, dir, moving, fault, edge_hit, bounce, lost, err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: mode 0 idle, 1 locked, 2 tracking, 3 fault.
    int m_mode = 0, m_pos = 0, m_dir = 0, m_cnt = 0;

    task automatic model_step(input bit r, input bit e, input logic [N-1:0] l, output exp_t x);
        int n, k, prev_pos, diff;
        bit prev_valid, ed, bo, lo, er;
        ed = 0; bo = 0; lo = 0; er = 0;
        if (r) begin
            m_mode = 0; m_pos = 0; m_dir = 0; m_cnt = 0;
        end else if (e) begin
            n = $countones(l);
            k = 0;
            for (int i = 0; i < N; i++) if (l[i]) k = i;
            prev_pos   = m_pos;
            prev_valid = (m_mode == 1 || m_mode == 2);
            diff       = k - m_pos;
            if (n == 0) begin
                if (prev_valid) begin lo = 1; m_mode = 0; end
            end else if (n > 1) begin
                if (m_mode != 3) er = 1;
                m_mode = 3;
            end else if (m_mode == 0 || m_mode == 3) begin
                m_mode = 1; m_pos = k;
            end else if (diff == 0) begin
                m_mode = 1;
            end else if (diff == 1 || diff == -1) begin
                if (m_mode == 2 && (diff > 0) != (m_dir == 1)) begin
                    bo = 1; m_cnt = (m_cnt + 1) % 256;
                end
                m_mode = 2; m_dir = (diff > 0) ? 1 : 0; m_pos = k;
            end else begin
                er = 1; m_mode = 3;
            end
            ed = (m_mode == 1 || m_mode == 2) && (!prev_valid || m_pos != prev_pos)
                 && (m_pos == 0 || m_pos == N - 1);
        end
        x.pos = PW'(m_pos);
        x.pos_valid = (m_mode == 1 || m_mode == 2);
        x.dir = m_dir[0];
        x.moving = (m_mode == 2);
        x.fault = (m_mode == 3);
        x.edge_hit = ed; x.bounce = bo; x.lost = lo; x.err = er;
`ifdef LIGHT_TRACKER_BOUNCE_CNT_EN
        x.cnt = CNT_W'(m_cnt);
`else
        x.cnt = '0;
`endif
    endtask

    task automatic drive(input bit r, input bit e, input logic [N-1:0] l);
        exp_t x;
        @(negedge clk);
        rst = r; ena = e; lights = l;
        model_step(r, e, l, x);
        exp_q.push_back(x);
    endtask

    // Monitor: one DUT observation per cycle, 1 time unit after the edge.
    initial begin
        exp_t x, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                a = {pos, pos_valid, dir, moving, fault, edge_hit, bounce, lost, err, cnt_obs};
                checks++;
                if (a !== x) begin
                    failures++;
                    $display("FAIL cycle_check t=%0t got pos=%0d pv=%b dir=%b mov=%b flt=%b edge=%b bnc=%b lost=%b err=%b cnt=%0d expected pos=%0d pv=%b dir=%b mov=%b flt=%b edge=%b bnc=%b lost=%b err=%b cnt=%0d",
                             $time, a.pos, a.pos_valid, a.dir, a.moving, a.fault, a.edge_hit, a.bounce, a.lost, a.err, a.cnt,
                             x.pos, x.pos_valid, x.dir, x.moving, x.fault, x.edge_hit, x.bounce, x.lost, x.err, x.cnt);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int cur;
        int r;
        logic [N-1:0] l;
        drive(1, 0, 8'h00);
        drive(1, 1, 8'h55);
        // Acquire and sweep left, bounce off the top, then lose the light.
        drive(0, 1, 8'h01);
        drive(0, 1, 8'h02);
        drive(0, 1, 8'h04);
        for (int i = 3; i < N; i++) drive(0, 1, 8'(1 << i));
        drive(0, 1, 8'h40);
        drive(0, 1, 8'h80);
        drive(0, 1, 8'h00);
        // Fault entry, stay in fault on MULTI, recover on a one-hot.
        drive(0, 1, 8'h04);
        drive(0, 1, 8'h20);
        drive(0, 1, 8'h18);
        drive(0, 1, 8'h08);
        drive(0, 1, 8'h10);
        drive(0, 1, 8'h20);
        for (int i = 0; i < 5; i++) drive(0, 0, 8'($urandom));
        drive(0, 1, 8'h40);
        drive(1, 1, 8'h80);
        drive(0, 1, 8'h01);
        drive(0, 1, 8'h02);
        drive(0, 1, 8'h01);
        drive(0, 1, 8'h00);

        cur = 3;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                if ($urandom_range(0, 1) == 1) cur = (cur < N - 1) ? cur + 1 : cur - 1;
                else                           cur = (cur > 0) ? cur - 1 : cur + 1;
                l = 8'(1 << cur);
            end else if (r < 70) begin
                l = 8'(1 << cur);
            end else if (r < 78) begin
                l = 8'h00;
            end else if (r < 86) begin
                l = 8'(1 << cur) | 8'(1 << ((cur + $urandom_range(1, N - 1)) % N));
            end else if (r < 94) begin
                cur = $urandom_range(0, N - 1);
                l = 8'(1 << cur);
            end else begin
                l = 8'($urandom);
            end
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), l);
        end
        drive(0, 0, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain left=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
